clic_irq_arb: RTL and testbench
===============================

CLIC_IRQ_ARB -- requirements
Module: clic_irq_arb

Interface
- REQ-001: Parameter N_CH, default 2, number of upstream CLIC irq channels (2..8).
- REQ-002: Parameter SRC_W, default 8, irq id width.
- REQ-003: Parameter PREEMPT, default 1'b1, enables preemption of an unaccepted offer by a strictly better request.
- REQ-004: clk_i  input  1  clock; one clock; reset is asynchronous and active-low.
- REQ-005: rst_ni  input  1  asynchronous active-low reset.
- REQ-006: ch_valid_i  input  N_CH  per-channel irq request valid.
- REQ-007: ch_ready_o  output  N_CH  per-channel irq accept.
- REQ-008: ch_id_i  input  N_CH x SRC_W  per-channel irq id.
- REQ-009: ch_level_i  input  N_CH x 8  per-channel irq level.
- REQ-010: ch_shv_i  input  N_CH  per-channel selective-hardware-vectoring flag.
- REQ-011: ch_priv_i  input  N_CH x 2  per-channel privilege mode.
- REQ-012: ch_kill_req_i  input  N_CH  per-channel withdraw request; ch_kill_ack_o  output  N_CH  per-channel withdraw ack.
- REQ-013: irq_valid_o, irq_id_o (SRC_W), irq_level_o (8), irq_shv_o, irq_priv_o (2)  outputs  core-side irq offer.
- REQ-014: irq_ch_o  output  $clog2(N_CH)  channel index of current offer.
- REQ-015: irq_ready_i  input  1  core accept; irq_kill_req_o  output  1  withdraw to core; irq_kill_ack_i  input  1  core withdraw ack.

Function
- REQ-016: Winner = valid channel with highest priv, then highest level, then lowest index; channels with kill_req asserted are excluded.
- REQ-017: States IDLE, OFFER, KILL_UP, KILL_PRE; reset state IDLE.
- REQ-018: IDLE: if any eligible channel, latch winner payload and index into registers, go OFFER; offer appears one cycle after ch_valid_i.
- REQ-019: OFFER: irq_valid_o=1, payload outputs from latched registers, stable until leaving OFFER.
- REQ-020: OFFER with irq_ready_i=1: ch_ready_o[sel]=1 same cycle (combinational), go IDLE; no other ch_ready_o bit ever asserts.
- REQ-021: OFFER with ch_kill_req_i[sel]=1 and no irq_ready_i: go KILL_UP.
- REQ-022: OFFER, PREEMPT=1, current eligible winner strictly better (priv,level) than latched, no irq_ready_i, no kill: go KILL_PRE; equal-rank never preempts.
- REQ-023: Priority in same cycle: irq_ready_i over upstream kill over preemption.
- REQ-024: KILL_UP/KILL_PRE: irq_valid_o=0, irq_kill_req_o=1 until irq_kill_ack_i=1; irq_ready_i ignored.
- REQ-025: KILL_UP on ack: ch_kill_ack_o[sel]=1 for one cycle (registered), go IDLE.
- REQ-026: KILL_PRE on ack: go IDLE; preempted channel stays pending, re-arbitrated normally.
- REQ-027: ch_kill_req_i on a non-selected channel, or selected channel after acceptance: ch_kill_ack_o for that channel one cycle later, without core handshake.
- REQ-028: irq_kill_req_o and irq_valid_o never both 1.
- REQ-029: Upstream channels hold valid and payload until ready or kill ack; violation is undefined.

Reset
- REQ-030: On rst_ni low, asynchronously: state IDLE, irq_valid_o=0, irq_kill_req_o=0, ch_ready_o=0, ch_kill_ack_o=0, latched payload and irq_ch_o=0.
- REQ-031: Reset mid-offer or mid-kill discards the transaction; no ack issued after reset release.

Structure
- REQ-032: Shared package clic_arb_pkg holds irq payload struct (id, level, shv, priv), state enum and rank-compare function.
- REQ-033: One sub-module clic_arb_tree: combinational N_CH winner selection returning valid, index and payload.

Verification
- REQ-034: ch0 valid level 0x40 priv 3, ch1 idle -> irq_valid_o next cycle, irq_ch_o=0, level 0x40; ready -> ch_ready_o=01, IDLE.
- REQ-035: ch0 and ch1 both priv 3 level 0x80 same cycle -> ch0 offered; after accept ch1 offered two cycles later.
- REQ-036: ch0 offered level 0x10, ch1 raises level 0x20 same priv, PREEMPT=1 -> kill_req, ack -> ch1 offered, then ch0 after ch1 accepted.
- REQ-037: ch0 offered, ch0 kill_req -> irq_valid_o=0, irq_kill_req_o=1; core ack after 3 cycles -> ch_kill_ack_o=01 one cycle, IDLE.
- REQ-038: irq_ready_i and ch1 better request same cycle -> ch0 accepted, no kill_req; ch1 offered next.
- REQ-039: rst_ni asserted in KILL_PRE -> all outputs 0 immediately; no ack after release.

Source files
------------

// File: rtl/clic_arb_pkg.sv
// rtl/clic_arb_pkg.sv - shared irq payload, arbiter state and rank compare
package clic_arb_pkg;

  // Widest supported irq id; narrower ids are zero-extended into the payload.
  localparam int unsigned ID_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OFFER    = 2'd1,
    ST_KILL_UP  = 2'd2,
    ST_KILL_PRE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [7:0]          level;
    logic                shv;
    logic [1:0]          priv;
  } irq_pay_t;

  // Strictly better rank: privilege first, then level; ties are never better.
  function automatic logic rank_better(input logic [1:0] a_priv, input logic [7:0] a_level,
                                       input logic [1:0] b_priv, input logic [7:0] b_level);
    return {a_priv, a_level} > {b_priv, b_level};
  endfunction

endpackage

// File: rtl/clic_arb_tree.sv
// rtl/clic_arb_tree.sv - combinational winner selection over eligible channels
module clic_arb_tree
  import clic_arb_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  elig_i,
  input  irq_pay_t         pay_i [N_CH],
  output logic             win_valid_o,
  output logic [IDX_W-1:0] win_idx_o,
  output irq_pay_t         win_pay_o
);

  logic             best_valid;
  logic [IDX_W-1:0] best_idx;
  irq_pay_t         best_pay;

  // Ascending scan with strict compare keeps the lowest index on equal rank.
  always_comb begin
    best_valid = 1'b0;
    best_idx   = '0;
    best_pay   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (elig_i[i] && (!best_valid ||
          rank_better(pay_i[i].priv, pay_i[i].level, best_pay.priv, best_pay.level))) begin
        best_valid = 1'b1;
        best_idx   = IDX_W'(i);
        best_pay   = pay_i[i];
      end
    end
  end

  assign win_valid_o = best_valid;
  assign win_idx_o   = best_idx;
  assign win_pay_o   = best_pay;

endmodule

// File: rtl/clic_irq_arb.sv
// rtl/clic_irq_arb.sv - arbitrates N_CH CLIC irq channels onto one core offer
module clic_irq_arb
  import clic_arb_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned SRC_W   = 8,
  parameter bit          PREEMPT = 1'b1,
  localparam int unsigned IDX_W  = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_CH-1:0]       ch_valid_i,
  output logic [N_CH-1:0]       ch_ready_o,
  input  logic [N_CH*SRC_W-1:0] ch_id_i,
  input  logic [N_CH*8-1:0]     ch_level_i,
  input  logic [N_CH-1:0]       ch_shv_i,
  input  logic [N_CH*2-1:0]     ch_priv_i,
  input  logic [N_CH-1:0]       ch_kill_req_i,
  output logic [N_CH-1:0]       ch_kill_ack_o,
  output logic                  irq_valid_o,
  output logic [SRC_W-1:0]      irq_id_o,
  output logic [7:0]            irq_level_o,
  output logic                  irq_shv_o,
  output logic [1:0]            irq_priv_o,
  output logic [IDX_W-1:0]      irq_ch_o,
  input  logic                  irq_ready_i,
  output logic                  irq_kill_req_o,
  input  logic                  irq_kill_ack_i
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  irq_pay_t         pay_q, pay_d;
  logic [N_CH-1:0]  kill_ack_q, kill_ack_d;

  irq_pay_t         ch_pay [N_CH];
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  irq_pay_t         win_pay;
  logic [N_CH-1:0]  sel_oh;
  logic [N_CH-1:0]  in_flight;
  logic             unused_id_hi;

  for (genvar g = 0; g < N_CH; g++) begin : g_pay
    assign ch_pay[g].id    = ID_MAX_W'(ch_id_i[g*SRC_W +: SRC_W]);
    assign ch_pay[g].level = ch_level_i[g*8 +: 8];
    assign ch_pay[g].shv   = ch_shv_i[g];
    assign ch_pay[g].priv  = ch_priv_i[g*2 +: 2];
  end

  clic_arb_tree #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_tree (
    .elig_i      (ch_valid_i & ~ch_kill_req_i),
    .pay_i       (ch_pay),
    .win_valid_o (win_valid),
    .win_idx_o   (win_idx),
    .win_pay_o   (win_pay)
  );

  assign sel_oh = N_CH'(1) << sel_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pay_d   = pay_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_OFFER;
          sel_d   = win_idx;
          pay_d   = win_pay;
        end
      end
      ST_OFFER: begin
        // Acceptance beats upstream withdraw, which beats preemption.
        if (irq_ready_i) begin
          state_d = ST_IDLE;
        end else if (|(ch_kill_req_i & sel_oh)) begin
          state_d = ST_KILL_UP;
        end else if (PREEMPT && win_valid &&
                     rank_better(win_pay.priv, win_pay.level, pay_q.priv, pay_q.level)) begin
          state_d = ST_KILL_PRE;
        end
      end
      ST_KILL_UP, ST_KILL_PRE: begin
        if (irq_kill_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The channel owned by the core cannot be withdrawn without the core's ack;
  // any other withdraw request is acked directly, once per request pulse.
  assign in_flight = (state_q == ST_OFFER || state_q == ST_KILL_UP) ? sel_oh : '0;

  always_comb begin
    kill_ack_d = ch_kill_req_i & ~in_flight & ~kill_ack_q;
    if (state_q == ST_KILL_UP && irq_kill_ack_i) kill_ack_d = kill_ack_d | sel_oh;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      pay_q      <= '0;
      kill_ack_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pay_q      <= pay_d;
      kill_ack_q <= kill_ack_d;
    end
  end

  assign irq_valid_o    = (state_q == ST_OFFER);
  assign irq_kill_req_o = (state_q == ST_KILL_UP) || (state_q == ST_KILL_PRE);
  assign ch_ready_o     = (state_q == ST_OFFER && irq_ready_i) ? sel_oh : '0;
  assign ch_kill_ack_o  = kill_ack_q;
  assign irq_id_o       = pay_q.id[SRC_W-1:0];
  assign irq_level_o    = pay_q.level;
  assign irq_shv_o      = pay_q.shv;
  assign irq_priv_o     = pay_q.priv;
  assign irq_ch_o       = sel_q;
  assign unused_id_hi   = ^pay_q.id;

endmodule

// File: tb/tb_clic_irq_arb.sv
// tb/tb_clic_irq_arb.sv - directed self-checking bench for clic_irq_arb
module tb_clic_irq_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ch_valid = '0, ch_ready, ch_shv = '0, ch_kill_req = '0, ch_kill_ack;
  logic [15:0] ch_id = '0, ch_level = '0;
  logic [3:0]  ch_priv = '0;
  logic        irq_valid, irq_shv, irq_ready = 1'b0, irq_kill_req, irq_kill_ack = 1'b0;
  logic [7:0]  irq_id, irq_level;
  logic [1:0]  irq_priv;
  logic [0:0]  irq_ch;
  int          pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  clic_irq_arb #(.N_CH(2), .SRC_W(8), .PREEMPT(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ch_valid_i(ch_valid), .ch_ready_o(ch_ready), .ch_id_i(ch_id), .ch_level_i(ch_level),
    .ch_shv_i(ch_shv), .ch_priv_i(ch_priv), .ch_kill_req_i(ch_kill_req), .ch_kill_ack_o(ch_kill_ack),
    .irq_valid_o(irq_valid), .irq_id_o(irq_id), .irq_level_o(irq_level), .irq_shv_o(irq_shv),
    .irq_priv_o(irq_priv), .irq_ch_o(irq_ch), .irq_ready_i(irq_ready),
    .irq_kill_req_o(irq_kill_req), .irq_kill_ack_i(irq_kill_ack)
  );

  task automatic set_ch(input int c, input logic v, input logic [7:0] id, input logic [7:0] lvl,
                        input logic [1:0] pr, input logic shv);
    ch_valid[c]        = v;
    ch_id[c*8 +: 8]    = id;
    ch_level[c*8 +: 8] = lvl;
    ch_priv[c*2 +: 2]  = pr;
    ch_shv[c]          = shv;
  endtask

  task automatic clear_all();
    ch_valid = '0; ch_id = '0; ch_level = '0; ch_priv = '0; ch_shv = '0;
    ch_kill_req = '0; irq_ready = 1'b0; irq_kill_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (irq_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", irq_valid); else pass_cnt++;
    total_cnt++; if (irq_kill_req !== 1'b0) $display("FAIL reset_kill_req: got %b want 0", irq_kill_req); else pass_cnt++;
    total_cnt++; if ({ch_ready, ch_kill_ack} !== 4'b0) $display("FAIL reset_ch_outs: got %b want 0000", {ch_ready, ch_kill_ack}); else pass_cnt++;
    total_cnt++; if ({irq_id, irq_level, irq_ch} !== 17'h0) $display("FAIL reset_payload: got %h want 0", {irq_id, irq_level, irq_ch}); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    set_ch(0, 1'b1, 8'h15, 8'h40, 2'd3, 1'b1);
    #1;
    total_cnt++; if (irq_valid !== 1'b0) $display("FAIL single_latency: got %b want 0", irq_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_ch, irq_level, irq_id} !== {1'b1, 1'b0, 8'h40, 8'h15})
      $display("FAIL single_offer: got v=%b ch=%0d lvl=%h id=%h want v=1 ch=0 lvl=40 id=15", irq_valid, irq_ch, irq_level, irq_id); else pass_cnt++;
    total_cnt++; if ({irq_shv, irq_priv} !== 3'b111) $display("FAIL single_attr: got %b want 111", {irq_shv, irq_priv}); else pass_cnt++;
    irq_ready = 1'b1; #1;
    total_cnt++; if (ch_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", ch_ready); else pass_cnt++;
    @(negedge clk);
    clear_all(); #1;
    total_cnt++; if ({irq_valid, ch_ready} !== 3'b000) $display("FAIL single_idle: got %b want 000", {irq_valid, ch_ready}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_tie();
    set_ch(0, 1'b1, 8'hA0, 8'h80, 2'd3, 1'b0);
    set_ch(1, 1'b1, 8'hA1, 8'h80, 2'd3, 1'b0);
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_ch, irq_id} !== {1'b1, 1'b0, 8'hA0}) $display("FAIL tie_first: got v=%b ch=%0d id=%h want 1/0/a0", irq_valid, irq_ch, irq_id); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_kill_req, irq_ch} !== 3'b100) $display("FAIL tie_no_preempt: got %b want 100", {irq_valid, irq_kill_req, irq_ch}); else pass_cnt++;
    irq_ready = 1'b1; #1;
    total_cnt++; if (ch_ready !== 2'b01) $display("FAIL tie_ready0: got %b want 01", ch_ready); else pass_cnt++;
    @(negedge clk);
    ch_valid[0] = 1'b0; irq_ready = 1'b0; #1;
    total_cnt++; if (irq_valid !== 1'b0) $display("FAIL tie_gap: got %b want 0", irq_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_ch, irq_id} !== {1'b1, 1'b1, 8'hA1}) $display("FAIL tie_second: got v=%b ch=%0d id=%h want 1/1/a1", irq_valid, irq_ch, irq_id); else pass_cnt++;
    irq_ready = 1'b1; #1;
    total_cnt++; if (ch_ready !== 2'b10) $display("FAIL tie_ready1: got %b want 10", ch_ready); else pass_cnt++;
    @(negedge clk);
    clear_all();
    @(negedge clk);
  endtask

  task automatic test_preempt();
    set_ch(0, 1'b1, 8'h30, 8'h10, 2'd1, 1'b0);
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_ch, irq_level} !== {1'b1, 1'b0, 8'h10}) $display("FAIL pre_offer0: got v=%b ch=%0d lvl=%h want 1/0/10", irq_valid, irq_ch, irq_level); else pass_cnt++;
    set_ch(1, 1'b1, 8'h31, 8'h20, 2'd1, 1'b0);
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_kill_req} !== 2'b01) $display("FAIL pre_kill: got %b want 01", {irq_valid, irq_kill_req}); else pass_cnt++;
    irq_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_kill_req, ch_ready} !== 4'b0100) $display("FAIL pre_hold: got %b want 0100", {irq_valid, irq_kill_req, ch_ready}); else pass_cnt++;
    irq_ready = 1'b0; irq_kill_ack = 1'b1;
    @(negedge clk);
    irq_kill_ack = 1'b0; #1;
    total_cnt++; if ({irq_valid, irq_kill_req, ch_kill_ack} !== 4'b0000) $display("FAIL pre_idle: got %b want 0000", {irq_valid, irq_kill_req, ch_kill_ack}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_ch, irq_level, irq_id} !== {1'b1, 1'b1, 8'h20, 8'h31}) $display("FAIL pre_offer1: got v=%b ch=%0d lvl=%h id=%h want 1/1/20/31", irq_valid, irq_ch, irq_level, irq_id); else pass_cnt++;
    irq_ready = 1'b1;
    @(negedge clk);
    ch_valid[1] = 1'b0; irq_ready = 1'b0;
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_ch, irq_id} !== {1'b1, 1'b0, 8'h30}) $display("FAIL pre_reoffer0: got v=%b ch=%0d id=%h want 1/0/30", irq_valid, irq_ch, irq_id); else pass_cnt++;
    irq_ready = 1'b1;
    @(negedge clk);
    clear_all();
    @(negedge clk);
  endtask

  task automatic test_upstream_kill();
    set_ch(0, 1'b1, 8'h50, 8'h40, 2'd2, 1'b0);
    @(negedge clk);
    ch_kill_req[0] = 1'b1;
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_kill_req} !== 2'b01) $display("FAIL kill_up_req: got %b want 01", {irq_valid, irq_kill_req}); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if ({irq_kill_req, ch_kill_ack} !== 3'b100) $display("FAIL kill_up_wait: got %b want 100", {irq_kill_req, ch_kill_ack}); else pass_cnt++;
    irq_kill_ack = 1'b1;
    @(negedge clk);
    total_cnt++; if ({ch_kill_ack, irq_kill_req, irq_valid} !== 4'b0100) $display("FAIL kill_up_ack: got %b want 0100", {ch_kill_ack, irq_kill_req, irq_valid}); else pass_cnt++;
    clear_all();
    @(negedge clk);
    total_cnt++; if ({ch_kill_ack, irq_valid} !== 3'b000) $display("FAIL kill_up_pulse: got %b want 000", {ch_kill_ack, irq_valid}); else pass_cnt++;
  endtask

  task automatic test_kill_idle();
    ch_kill_req[1] = 1'b1;
    @(negedge clk);
    total_cnt++; if ({ch_kill_ack, irq_kill_req} !== 3'b100) $display("FAIL kill_idle_ack: got %b want 100", {ch_kill_ack, irq_kill_req}); else pass_cnt++;
    ch_kill_req[1] = 1'b0;
    @(negedge clk);
    total_cnt++; if (ch_kill_ack !== 2'b00) $display("FAIL kill_idle_pulse: got %b want 00", ch_kill_ack); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    set_ch(0, 1'b1, 8'h60, 8'h10, 2'd1, 1'b0);
    @(negedge clk);
    set_ch(1, 1'b1, 8'h61, 8'h90, 2'd3, 1'b1);
    irq_ready = 1'b1; #1;
    total_cnt++; if (ch_ready !== 2'b01) $display("FAIL b2b_ready: got %b want 01", ch_ready); else pass_cnt++;
    @(negedge clk);
    ch_valid[0] = 1'b0; irq_ready = 1'b0; #1;
    total_cnt++; if ({irq_valid, irq_kill_req} !== 2'b00) $display("FAIL b2b_no_kill: got %b want 00", {irq_valid, irq_kill_req}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({irq_valid, irq_ch, irq_id, irq_shv} !== {1'b1, 1'b1, 8'h61, 1'b1}) $display("FAIL b2b_offer1: got v=%b ch=%0d id=%h shv=%b want 1/1/61/1", irq_valid, irq_ch, irq_id, irq_shv); else pass_cnt++;
    irq_ready = 1'b1;
    @(negedge clk);
    clear_all();
    @(negedge clk);
  endtask

  task automatic test_reset_in_kill();
    set_ch(0, 1'b1, 8'h70, 8'h10, 2'd0, 1'b0);
    @(negedge clk);
    set_ch(1, 1'b1, 8'h71, 8'h20, 2'd0, 1'b0);
    @(negedge clk);
    total_cnt++; if (irq_kill_req !== 1'b1) $display("FAIL rst_pre_state: got %b want 1", irq_kill_req); else pass_cnt++;
    rst_n = 1'b0; #1;
    total_cnt++; if ({irq_valid, irq_kill_req, ch_ready, ch_kill_ack, irq_level, irq_ch} !== 15'h0)
      $display("FAIL rst_async: got %h want 0", {irq_valid, irq_kill_req, ch_ready, ch_kill_ack, irq_level, irq_ch}); else pass_cnt++;
    clear_all(); irq_kill_ack = 1'b1;
    @(negedge clk);
    irq_kill_ack = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if ({irq_valid, irq_kill_req, ch_kill_ack} !== 4'b0000) $display("FAIL rst_no_ack: got %b want 0000", {irq_valid, irq_kill_req, ch_kill_ack}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_preempt();
    test_upstream_kill();
    test_kill_idle();
    test_back_to_back();
    test_reset_in_kill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
